// File: rtl/alignment.sv
// Exponent-alignment stage ahead of the FP adder: picks the larger-exponent operand
// and right-shifts the other significand one bit per cycle, folding lost bits into sticky.
module alignment #(
  parameter bit EARLY_FLUSH = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  expA,
  input  logic [7:0]  expB,
  input  logic [23:0] fracA,
  input  logic [23:0] fracB,
  output logic        busy,
  output logic        done,
  output logic        swap,
  output logic [7:0]  expAlign,
  output logic [26:0] fracLarge,
  output logic [26:0] fracSmall
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] FLUSH_DIST = 8'd27;

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        swap_q, swap_d;
  logic [7:0]  exp_align_q, exp_align_d;
  logic [26:0] frac_large_q, frac_large_d;
  logic [26:0] frac_small_q, frac_small_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        a_large;
  logic [7:0]  diff;
  logic [23:0] large_sig;
  logic [23:0] small_sig;
  logic [7:0]  count_dec;

  always_comb begin
    a_large   = (expA >= expB);
    diff      = a_large ? (expA - expB) : (expB - expA);
    large_sig = a_large ? fracA : fracB;
    small_sig = a_large ? fracB : fracA;
    count_dec = count_q - 8'd1;

    state_d      = state_q;
    count_d      = count_q;
    swap_d       = swap_q;
    exp_align_d  = exp_align_q;
    frac_large_d = frac_large_q;
    frac_small_d = frac_small_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          swap_d       = ~a_large;
          exp_align_d  = a_large ? expA : expB;
          frac_large_d = {large_sig, 3'b000};
          frac_small_d = {small_sig, 3'b000};
          count_d      = diff;
          if (diff == 8'd0) begin
            state_d = DONE;
          end else if (EARLY_FLUSH && (diff >= FLUSH_DIST)) begin
            // Every significand bit would land in sticky anyway, so skip the iteration.
            frac_small_d = {26'd0, |small_sig};
            state_d      = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        frac_small_d = {1'b0, frac_small_q[26:2], frac_small_q[1] | frac_small_q[0]};
        count_d      = count_dec;
        if (count_dec == 8'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      swap_q       <= 1'b0;
      exp_align_q  <= '0;
      frac_large_q <= '0;
      frac_small_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      swap_q       <= swap_d;
      exp_align_q  <= exp_align_d;
      frac_large_q <= frac_large_d;
      frac_small_q <= frac_small_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign swap      = swap_q;
  assign expAlign  = exp_align_q;
  assign fracLarge = frac_large_q;
  assign fracSmall = frac_small_q;

endmodule
